// File: rtl/clk_div_pkg.sv
// Shared constants for the clk_div_gen tick generator.
// Reference clock rate and default divisors for the standard channel set:
//   ch 0 = 1 Hz timekeeping, ch 1 = 2 Hz flash, ch 2 = 1 kHz scan,
//   ch 3 = 100 Hz debounce.
package clk_div_pkg;

  localparam int CNT_W_DEF = 27;
  localparam int CLK_HZ    = 100_000_000;

  localparam int DIV_1HZ   = 100_000_000;
  localparam int DIV_2HZ   = 50_000_000;
  localparam int DIV_1KHZ  = 100_000;
  localparam int DIV_100HZ = 1_000_000;

  localparam int CH_1HZ  = 0;
  localparam int CH_2HZ  = 1;
  localparam int CH_SCAN = 2;
  localparam int CH_DB   = 3;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Control/status bundle of clk_div_gen.
//   master: drives ch_en, sync, wr_en, wr_ch, wr_div; reads tick, sq, pend, wr_err
//   slave : the generator side (opposite directions)
interface clk_div_gen_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int WCH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              wr_en;
  logic [WCH_W-1:0]  wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] pend;
  logic              wr_err;

  modport master (
    output ch_en, sync, wr_en, wr_ch, wr_div,
    input  tick, sq, pend, wr_err
  );

  modport slave (
    input  ch_en, sync, wr_en, wr_ch, wr_div,
    output tick, sq, pend, wr_err
  );

endinterface

// File: rtl/clk_div_ch.sv
// One tick-generator channel: period counter, shadowed divisor with
// boundary commit, registered tick pulse and square wave.
//   clk, rst_n : clock, async active-low reset
//   en_i       : run enable (low holds the counter at 0)
//   sync_i     : restart counter, commit any pending divisor
//   wr_i       : accepted write targeting this channel
//   wr_div_i   : divisor carried by that write
//   tick_o     : one-cycle pulse per period
//   sq_o       : high for floor(div/2) cycles of each period
//   pend_o     : shadow divisor awaiting commit
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             wrap;

  assign wrap = (cnt_q == act_div_q - CNT_W'(1));

  always_comb begin
    // A write landing in a boundary cycle is folded in before the commit,
    // so it takes effect at that boundary and pend never rises.
    shadow_d  = wr_i ? wr_div_i : shadow_q;
    pend_d    = pend_q | wr_i;
    act_div_d = act_div_q;
    cnt_d     = cnt_q + CNT_W'(1);
    tick_d    = 1'b0;
    if (!en_i || sync_i || wrap) begin
      cnt_d = '0;
      if (pend_d) act_div_d = shadow_d;
      pend_d = 1'b0;
      tick_d = en_i && !sync_i;
    end
    sq_d = en_i && (cnt_d < (act_div_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      act_div_q <= DEF_DIV;
      shadow_q  <= DEF_DIV;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// N-channel tick generator with runtime-programmable, glitch-free divisors.
// Outputs are clock enables for logic on clk; no derived clocks.
//   clk, rst_n : 100 MHz system clock, async active-low reset
//   bus        : clk_div_gen_if slave (ch_en, sync, write port in;
//                tick, sq, pend, wr_err out)
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH  = 4,
  parameter int                      CNT_W   = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {CNT_W'(DIV_100HZ), CNT_W'(DIV_1KHZ),
                                                CNT_W'(DIV_2HZ),   CNT_W'(DIV_1HZ)}
) (
  input logic          clk,
  input logic          rst_n,
  clk_div_gen_if.slave bus
);

  logic              wr_ok;
  logic              wr_err_q, wr_err_d;
  logic [NUM_CH-1:0] tick_w, sq_w, pend_w;

  // Channel index is range-checked because NUM_CH need not be a power of 2.
  assign wr_ok    = bus.wr_en && (bus.wr_div != '0) && (32'(bus.wr_ch) < NUM_CH);
  assign wr_err_d = bus.wr_en && !wr_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (bus.ch_en[g]),
      .sync_i   (bus.sync),
      .wr_i     (wr_ok && (32'(bus.wr_ch) == g)),
      .wr_div_i (bus.wr_div),
      .tick_o   (tick_w[g]),
      .sq_o     (sq_w[g]),
      .pend_o   (pend_w[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_err_d;
  end

  assign bus.tick   = tick_w;
  assign bus.sq     = sq_w;
  assign bus.pend   = pend_w;
  assign bus.wr_err = wr_err_q;

endmodule
